soc_mmio_fabric: RTL
====================

# soc_mmio_fabric

Parametrised memory-mapped interconnect between the cpu6 data port and NSLV peripheral slaves (RAM, text VGA, LIC, UART, future devices). It replaces hard-wired per-device address compares and the combinational read mux. Per-slave base/mask decode uses lowest-index priority. A single-outstanding request/response handshake gives registered outputs and slave wait-states. Unmapped or stalled accesses return an error response instead of silently aliasing to RAM.

## Interface
Parameters:
- NSLV, 4, number of slave channels (1..16)
- AW, 32, address width
- DW, 32, data width
- SLV_BASE, {NSLV{AW'h0}}, flattened per-slave base addresses; slave i occupies bits [i*AW +: AW]
- SLV_MASK, {NSLV{AW'h0}}, flattened per-slave compare masks; 1 = bit compared
- TIMEOUT, 255, maximum wait-state cycles before error (1..2^16-1)

Ports:
- clk  in  1  single clock; all state on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  master request
- req_ready  out  1  fabric can accept
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  byte address
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DW  read data; 0 on write or error
- rsp_err  out  1  decode error or timeout
- s_sel  out  NSLV  one-hot slave select, held for the whole access
- s_write  out  1  latched req_write
- s_addr  out  AW  latched req_addr
- s_wdata  out  DW  latched req_wdata
- s_ready  in  NSLV  per-slave completion; sampled only for the selected slave
- s_rdata  in  NSLV*DW  flattened per-slave read data, valid with s_ready

## Operation
- Decode: slave i matches when (req_addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]). The lowest matching index wins. No match means decode error.
- FSM states are IDLE, ACCESS and RESP.
- IDLE: req_ready=1. On req_valid, latch write/addr/wdata and the decoded one-hot.
  - If a slave matches: go to ACCESS.
  - If no slave matches: go to RESP with err=1.
- ACCESS: s_sel = latched one-hot. On s_ready[sel], capture s_rdata[sel] (forced to 0 if write) and go to RESP with err=0. s_ready of non-selected slaves is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0, so no new request is accepted in this cycle.
- Writes to unmapped addresses are dropped; no s_sel is asserted.
- Reset values: req_ready=0 during reset, 1 in the first cycle after reset. rsp_valid=0, rsp_rdata=0, rsp_err=0, s_sel=0, s_write=0, s_addr=0, s_wdata=0, FSM=IDLE, timeout counter=0.
- Reset asserted mid-access: the transaction is abandoned, no response is issued, and s_sel drops in the next cycle.

## Timing
- Request accepted at edge t (req_valid & req_ready).
- s_sel is high from t+1.
- Zero-wait slave (s_ready high at t+1): rsp_valid at t+2.
- Each extra wait cycle adds 1 cycle of latency.
- Decode error: rsp_valid/rsp_err at t+1.
- Throughput: at most one transaction per 3 cycles (2 on decode error).
- All outputs are driven from registers. There is no combinational path from s_ready or s_rdata to rsp_*.

## Configuration
- SOC_MMIO_TIMEOUT_EN defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without s_ready[sel].
  - When the count reaches TIMEOUT, go to RESP with err=1 and rdata=0, and deassert s_sel.
  - If s_ready arrives in the same cycle the count reaches TIMEOUT, s_ready wins and err=0.
- SOC_MMIO_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely. The TIMEOUT parameter is ignored.

## Structure
- Package soc_mmio_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - default map constants: RAM base 0x00000000 mask 0xFFFF0000; VGA base 0x00010000 mask 0xFFFF0000; LIC base 0x00020000 mask 0xFFFFF000; UART base 0x00021000 mask 0xFFFFF000
- Sub-module soc_mmio_decode: combinational base/mask compare plus priority encoder, with outputs hit and sel_onehot[NSLV]. The FSM and registers live in soc_mmio_fabric.

## Test plan
- Default map, read of 0x00021000 with UART slave ready at first ACCESS cycle returning 0x35: s_sel=4'b1000 at t+1; rsp_valid at t+2 with rdata=0x35, err=0.
- Write 0xDEADBEEF to 0x00010004 with VGA slave holding s_ready low for 3 cycles: s_sel=4'b0010 held 4 cycles, s_wdata=0xDEADBEEF; rsp at t+5 with rdata=0, err=0.
- Read of 0x00030000: no s_sel; rsp at t+1 with err=1, rdata=0.
- Overlapping map (slave0 mask 0, slave1 base 0x20000): read of 0x20000 selects slave0 only.
- SOC_MMIO_TIMEOUT_EN with TIMEOUT=4, LIC never ready: err response after 4 ACCESS cycles, s_sel low in the RESP cycle. Repeat with s_ready on cycle 4: err=0.
- Reset asserted during ACCESS: no rsp_valid, s_sel=0 next cycle, req_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/soc_mmio_pkg.sv
// soc_mmio_pkg
// Shared definitions for the MMIO fabric slice.
//   state_t            : fabric FSM encoding (IDLE, ACCESS, RESP)
//   *_BASE / *_MASK    : default cpu6 memory map (RAM, VGA, LIC, UART)
//   DEFAULT_SLV_BASE/MASK : the default map flattened in slave-index order,
//                         slave i at bits [i*32 +: 32]
// No configuration macros are used in this file.
package soc_mmio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_NSLV = 4;

   localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] RAM_MASK  = 32'hFFFF_0000;
   localparam logic [31:0] VGA_BASE  = 32'h0001_0000;
   localparam logic [31:0] VGA_MASK  = 32'hFFFF_0000;
   localparam logic [31:0] LIC_BASE  = 32'h0002_0000;
   localparam logic [31:0] LIC_MASK  = 32'hFFFF_F000;
   localparam logic [31:0] UART_BASE = 32'h0002_1000;
   localparam logic [31:0] UART_MASK = 32'hFFFF_F000;

   // Slave 0 sits in the least significant slot, so RAM is concatenated last.
   localparam logic [DEFAULT_NSLV*32-1:0] DEFAULT_SLV_BASE =
      {UART_BASE, LIC_BASE, VGA_BASE, RAM_BASE};
   localparam logic [DEFAULT_NSLV*32-1:0] DEFAULT_SLV_MASK =
      {UART_MASK, LIC_MASK, VGA_MASK, RAM_MASK};

endpackage

// File: rtl/soc_mmio_decode.sv
// soc_mmio_decode
// Combinational address decoder: each slave compares the masked address
// against its masked base, and the lowest matching index wins.
// Ports:
//   addr       in  AW    byte address to decode
//   hit        out 1     at least one slave matched
//   sel_onehot out NSLV  one-hot winner (all zero when hit is 0)
// No configuration macros are used in this file.
module soc_mmio_decode #(
   parameter int unsigned          NSLV     = 4,
   parameter int unsigned          AW       = 32,
   parameter logic [NSLV*AW-1:0]   SLV_BASE = '0,
   parameter logic [NSLV*AW-1:0]   SLV_MASK = '0
) (
   input  logic [AW-1:0]   addr,
   output logic            hit,
   output logic [NSLV-1:0] sel_onehot
);

   // Scan upward and stop claiming once a match is found, which gives the
   // lowest index priority when slave windows overlap.
   always_comb begin
      hit        = 1'b0;
      sel_onehot = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (!hit &&
             ((addr & SLV_MASK[i*AW +: AW]) ==
              (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))) begin
            hit           = 1'b1;
            sel_onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/soc_mmio_fabric.sv
// soc_mmio_fabric
// Single-outstanding MMIO interconnect between the cpu6 data port and NSLV
// peripheral slaves. Requests are decoded by base/mask, forwarded on a
// latched slave bus, and answered with a one-cycle registered response.
// Unmapped addresses return an error response without touching any slave.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   master request handshake
//   req_write/addr/wdata  master request fields
//   rsp_valid/rdata/err   one-cycle response pulse, rdata 0 on write or error
//   s_sel                 one-hot slave select, held for the whole access
//   s_write/addr/wdata    latched request fields towards the slaves
//   s_ready               per-slave completion, only the selected bit is used
//   s_rdata               flattened per-slave read data, slave i at [i*DW +: DW]
// Configuration:
//   SOC_MMIO_TIMEOUT_EN   when defined, an access that waits TIMEOUT cycles
//                         without completion ends with an error response.
module soc_mmio_fabric
   import soc_mmio_pkg::*;
#(
   parameter int unsigned          NSLV     = 4,
   parameter int unsigned          AW       = 32,
   parameter int unsigned          DW       = 32,
   parameter logic [NSLV*AW-1:0]   SLV_BASE = '0,
   parameter logic [NSLV*AW-1:0]   SLV_MASK = '0,
   parameter int unsigned          TIMEOUT  = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [AW-1:0]      req_addr,
   input  logic [DW-1:0]      req_wdata,
   output logic               rsp_valid,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic [NSLV-1:0]    s_sel,
   output logic               s_write,
   output logic [AW-1:0]      s_addr,
   output logic [DW-1:0]      s_wdata,
   input  logic [NSLV-1:0]    s_ready,
   input  logic [NSLV*DW-1:0] s_rdata
);

   state_t            state, state_d;
   logic              dec_hit;
   logic [NSLV-1:0]   dec_onehot;
   logic              sel_ready;
   logic [DW-1:0]     sel_rdata;

   logic              req_ready_d;
   logic              rsp_valid_d;
   logic [DW-1:0]     rsp_rdata_d;
   logic              rsp_err_d;
   logic [NSLV-1:0]   s_sel_d;
   logic              s_write_d;
   logic [AW-1:0]     s_addr_d;
   logic [DW-1:0]     s_wdata_d;

`ifdef SOC_MMIO_TIMEOUT_EN
   logic [15:0]       timeout_cnt, timeout_cnt_d;
   logic              timeout_hit;
`endif

   soc_mmio_decode #(
      .NSLV     (NSLV),
      .AW       (AW),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_decode (
      .addr       (req_addr),
      .hit        (dec_hit),
      .sel_onehot (dec_onehot)
   );

   // Only the latched selected slave may complete the access; the read data
   // is an AND-OR mux so a zero s_sel yields zero data.
   always_comb begin
      sel_ready = |(s_ready & s_sel);
      sel_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (s_sel[i]) begin
            sel_rdata = sel_rdata | s_rdata[i*DW +: DW];
         end
      end
   end

`ifdef SOC_MMIO_TIMEOUT_EN
   // The limit is reached on the ACCESS cycle whose increment would make the
   // count equal to TIMEOUT.
   always_comb begin
      timeout_hit = (({1'b0, timeout_cnt} + 17'd1) == 17'(TIMEOUT));
   end
`endif

   // Next-state and next-output logic. Every output is registered, so this
   // block computes the values they take at the coming edge.
   always_comb begin
      state_d     = state;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      s_sel_d     = s_sel;
      s_write_d   = s_write;
      s_addr_d    = s_addr;
      s_wdata_d   = s_wdata;
`ifdef SOC_MMIO_TIMEOUT_EN
      timeout_cnt_d = timeout_cnt;
`endif
      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               s_write_d = req_write;
               s_addr_d  = req_addr;
               s_wdata_d = req_wdata;
               s_sel_d   = dec_onehot;
               if (dec_hit) begin
                  state_d = ACCESS;
`ifdef SOC_MMIO_TIMEOUT_EN
                  timeout_cnt_d = '0;
`endif
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (sel_ready) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = s_write ? '0 : sel_rdata;
               s_sel_d     = '0;
            end
`ifdef SOC_MMIO_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               s_sel_d     = '0;
            end else begin
               timeout_cnt_d = timeout_cnt + 16'd1;
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            s_sel_d = '0;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   // State and output registers. req_ready is itself a register, so it is low
   // throughout reset and rises on the first edge after reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         s_sel     <= '0;
         s_write   <= 1'b0;
         s_addr    <= '0;
         s_wdata   <= '0;
`ifdef SOC_MMIO_TIMEOUT_EN
         timeout_cnt <= '0;
`endif
      end else begin
         state     <= state_d;
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         s_sel     <= s_sel_d;
         s_write   <= s_write_d;
         s_addr    <= s_addr_d;
         s_wdata   <= s_wdata_d;
`ifdef SOC_MMIO_TIMEOUT_EN
         timeout_cnt <= timeout_cnt_d;
`endif
      end
   end

endmodule
